ram_sp_pipe: RTL and testbench
==============================

RAM_SP_PIPE -- requirements
Module: ram_sp_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 6, giving depth = 2**ADDR_W words.
REQ-003 The block SHALL have parameter READ_LAT, default 1, legal range 1..4, giving the read latency in ce-enabled cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port ce, input, 1 bit: clock enable; low freezes all state, including the pipeline, clear sweep and outputs.
REQ-007 The block SHALL have port enable, input, 1 bit: access request.
REQ-008 The block SHALL have port r_w, input, 1 bit: 0 = read, 1 = write.
REQ-009 The block SHALL have port add, input, ADDR_W bits: word address.
REQ-010 The block SHALL have port data_in, input, DATA_W bits: write data.
REQ-011 The block SHALL have port ready, output, 1 bit: high when a request can be accepted.
REQ-012 The block SHALL have port data_out, output, DATA_W bits: registered read data.
REQ-013 The block SHALL have port data_valid, output, 1 bit: one-cycle strobe qualifying data_out.

Function
REQ-014 A request SHALL be accepted on a rising edge where enable=1, ce=1, ready=1 and rst=0; it is ignored otherwise, with no side effect.
REQ-015 An accepted write SHALL update memory[add] with data_in at that edge; data_valid is not raised.
REQ-016 An accepted read SHALL sample memory[add] at the acceptance edge (before any write at the same edge).
REQ-017 Read timing: the read result SHALL appear on data_out, with data_valid=1, exactly READ_LAT ce-enabled edges after acceptance.
REQ-018 Reads SHALL be fully pipelined: one accepted read per cycle is sustainable, and results return in order.
REQ-019 data_valid SHALL be high for exactly one ce-enabled cycle per read; data_out holds its last value otherwise.
REQ-020 Mixed traffic: a write accepted after a read SHALL NOT alter that read's returned data; a read accepted on the cycle after a write to the same address SHALL return the new data.
REQ-021 When ce=0, data_out, data_valid, ready and all internal state SHALL hold; in-flight reads resume when ce returns.
REQ-022 The state machine SHALL have two states, CLEAR (ready=0) and IDLE (ready=1).

Reset
REQ-023 While rst=1, at each edge: data_out=0, data_valid=0, ready=0, the read pipeline is flushed, and the clear address counter=0; reset ignores ce.
REQ-024 Reset asserted mid-operation SHALL discard in-flight reads; no data_valid is issued for them.
REQ-025 Memory contents SHALL NOT be affected by rst itself (see REQ-026).

Configuration
REQ-026 With macro RAM_SP_PIPE_CLEAR_EN defined, after rst falls the block SHALL enter CLEAR and write 0 to addresses 0..2**ADDR_W-1, one per ce-enabled cycle, then enter IDLE; ready rises 2**ADDR_W ce-enabled cycles after reset release.
REQ-027 Without RAM_SP_PIPE_CLEAR_EN, the block SHALL enter IDLE on the first edge after rst falls (ready=1), and memory contents SHALL be left undefined.

Verification
REQ-028 Defaults, CLEAR_EN defined: release rst, then count cycles -> ready=0 for 64 cycles then 1; a read of any address returns 0x0000.
REQ-029 Defaults: write 0xBEEF to add 5, read add 5 next cycle -> data_valid one cycle later with data_out=0xBEEF.
REQ-030 READ_LAT=3: back-to-back reads of add 1,2,3 holding 0x0011,0x0022,0x0033 -> data_valid high for 3 consecutive cycles starting 3 cycles after the first acceptance, data in order.
REQ-031 READ_LAT=2: accept read add 7 (0x1234), drop ce for 4 cycles, then raise ce -> data_valid two ce-enabled edges after acceptance, data_out=0x1234, outputs frozen during ce=0.
REQ-032 Assert rst one cycle after accepting a read (READ_LAT=2) -> no data_valid is issued, data_out=0, and without CLEAR_EN memory retains prior writes (add 5 still reads 0xBEEF).
REQ-033 enable=1 with ready=0 during CLEAR, r_w=1, data_in=0xFFFF -> write is ignored; the address reads 0x0000 after CLEAR.

Source files
------------

// File: rtl/ram_sp_pipe.sv
// Single-port RAM with READ_LAT-deep registered read pipeline; RAM_SP_PIPE_CLEAR_EN zero-fills memory after reset.
// Read data valid READ_LAT ce-enabled edges after acceptance; ready low while clearing or in reset, ce=0 freezes everything.
module ram_sp_pipe #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              enable,
    input  logic              r_w,
    input  logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [READ_LAT-1:0] pipe_vld;
    logic [DATA_W-1:0] pipe_dat [READ_LAT];

    logic              acc_rd;
    logic              acc_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    assign ready  = (state == ST_IDLE);
    assign acc_rd = enable & ce & ready & ~rst & ~r_w;
    assign acc_wr = enable & ce & ready & ~rst & r_w;

`ifdef RAM_SP_PIPE_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;

    // Sweep one address per ce-enabled cycle; the last write moves to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else if (ce && state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == '1)
                state <= ST_IDLE;
        end
    end

    always_comb begin
        mem_we = acc_wr;
        mem_wa = add;
        mem_wd = data_in;
        if (ce && !rst && state == ST_CLEAR) begin
            mem_we = 1'b1;
            mem_wa = clr_addr;
            mem_wd = '0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_CLEAR;
        else if (ce)
            state <= ST_IDLE;
    end

    always_comb begin
        mem_we = acc_wr;
        mem_wa = add;
        mem_wd = data_in;
    end
`endif

    // No reset on the array: contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    // Read samples the pre-write contents at the acceptance edge.
    always_ff @(posedge clk) begin
        if (ce) begin
            pipe_dat[0] <= mem[add];
            for (int i = 1; i < READ_LAT; i++)
                pipe_dat[i] <= pipe_dat[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld   <= '0;
            data_valid <= 1'b0;
            data_out   <= '0;
        end else if (ce) begin
            pipe_vld[0] <= acc_rd;
            for (int i = 1; i < READ_LAT; i++)
                pipe_vld[i] <= pipe_vld[i-1];
            data_valid <= pipe_vld[READ_LAT-1];
            if (pipe_vld[READ_LAT-1])
                data_out <= pipe_dat[READ_LAT-1];
        end
    end

endmodule

// File: tb/tb_ram_sp_pipe.sv
// Bench for ram_sp_pipe at READ_LAT=2: directed table, hand sequences and random traffic vs. a queue-based model.
module tb_ram_sp_pipe;

    localparam int LAT = 2;
`ifdef RAM_SP_PIPE_CLEAR_EN
    localparam int CLR_CYC = 64;
`else
    localparam int CLR_CYC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        enable = 1'b0;
    logic        r_w = 1'b0;
    logic [5:0]  add = '0;
    logic [15:0] data_in = '0;
    logic        ready;
    logic [15:0] data_out;
    logic        data_valid;

    ram_sp_pipe #(.DATA_W(16), .ADDR_W(6), .READ_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .ce(ce), .enable(enable), .r_w(r_w), .add(add),
        .data_in(data_in), .ready(ready), .data_out(data_out), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: memory array, queue of outstanding reads stamped with their due edge.
    typedef struct {
        int          due;
        logic [15:0] d;
        bit          k;
    } pend_t;

    pend_t       q[$];
    logic [15:0] mm[64];
    bit          mk[64];
    int          edges = 0;
    int          rel = 0;
    bit          m_ready = 1'b0;
    bit          m_vld = 1'b0;
    logic [15:0] m_dout = '0;
    bit          m_dknown = 1'b1;

    typedef struct {
        bit          rw;
        bit          en;
        logic [5:0]  a;
        logic [15:0] d;
        bit          x_vld;
        logic [15:0] x_dout;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit c, input bit e, input bit w,
                              input logic [5:0] a, input logic [15:0] d);
        pend_t p;
        bit acc;
        if (r) begin
            q.delete();
            m_vld = 0; m_dout = '0; m_dknown = 1; m_ready = 0; rel = 0;
        end else if (c) begin
            acc = e && m_ready;
            edges++;
            m_vld = 0;
            if (q.size() > 0 && q[0].due == edges) begin
                m_vld = 1; m_dout = q[0].d; m_dknown = q[0].k;
                void'(q.pop_front());
            end
            if (acc && !w) begin
                p.due = edges + LAT; p.d = mm[a]; p.k = mk[a];
                q.push_back(p);
            end
            if (acc && w) begin
                mm[a] = d; mk[a] = 1;
            end
            if (!m_ready) begin
                rel++;
                if (rel >= CLR_CYC) begin
                    m_ready = 1;
`ifdef RAM_SP_PIPE_CLEAR_EN
                    for (int i = 0; i < 64; i++) begin mm[i] = '0; mk[i] = 1; end
`endif
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit c, input bit e, input bit w,
                        input logic [5:0] a, input logic [15:0] d);
        rst = r; ce = c; enable = e; r_w = w; add = a; data_in = d;
        @(posedge clk);
        model_edge(r, c, e, w, a, d);
        #1;
        chk("ready", {31'b0, ready}, {31'b0, m_ready});
        chk("data_valid", {31'b0, data_valid}, {31'b0, m_vld});
        if (m_dknown)
            chk("data_out", {16'b0, data_out}, {16'b0, m_dout});
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            step(0, 1, 1, 1, 6'd9, 16'hFFFF);
            n++;
        end
        chk("ready_rise_cycles", n, CLR_CYC);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin mm[i] = '0; mk[i] = 0; end

        tbl[0]  = '{1, 1, 6'd5, 16'hBEEF, 0, 16'h0000};
        tbl[1]  = '{0, 1, 6'd5, 16'h0000, 0, 16'h0000};
        tbl[2]  = '{0, 0, 6'd0, 16'h0000, 0, 16'h0000};
        tbl[3]  = '{0, 0, 6'd0, 16'h0000, 1, 16'hBEEF};
        tbl[4]  = '{0, 0, 6'd0, 16'h0000, 0, 16'hBEEF};
        tbl[5]  = '{1, 1, 6'd7, 16'h1234, 0, 16'hBEEF};
        tbl[6]  = '{1, 1, 6'd1, 16'h0011, 0, 16'hBEEF};
        tbl[7]  = '{1, 1, 6'd2, 16'h0022, 0, 16'hBEEF};
        tbl[8]  = '{1, 1, 6'd3, 16'h0033, 0, 16'hBEEF};
        tbl[9]  = '{0, 1, 6'd1, 16'h0000, 0, 16'hBEEF};
        tbl[10] = '{0, 1, 6'd2, 16'h0000, 0, 16'hBEEF};
        tbl[11] = '{0, 1, 6'd3, 16'h0000, 1, 16'h0011};
        tbl[12] = '{1, 1, 6'd1, 16'h5555, 1, 16'h0022};
        tbl[13] = '{0, 1, 6'd1, 16'h0000, 1, 16'h0033};
        tbl[14] = '{0, 0, 6'd0, 16'h0000, 0, 16'h0033};
        tbl[15] = '{0, 0, 6'd0, 16'h0000, 1, 16'h5555};
        tbl[16] = '{0, 0, 6'd0, 16'h0000, 0, 16'h5555};

        // Reset, including one edge with ce low; then release and wait out the clear sweep.
        step(1, 1, 1, 0, 6'd0, 16'h0);
        step(1, 0, 1, 1, 6'd3, 16'hAAAA);
        step(1, 1, 0, 0, 6'd0, 16'h0);
        wait_ready();

        foreach (tbl[i]) begin
            step(0, 1, tbl[i].en, tbl[i].rw, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_vld", i), {31'b0, data_valid}, {31'b0, tbl[i].x_vld});
            chk($sformatf("tbl%0d_dout", i), {16'b0, data_out}, {16'b0, tbl[i].x_dout});
        end

        // ce freeze with a read in flight; requests during ce=0 are ignored.
        step(0, 1, 1, 0, 6'd7, 16'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 6'd5, 16'h0);
            chk("freeze_vld", {31'b0, data_valid}, 32'd0);
            chk("freeze_dout", {16'b0, data_out}, 32'h5555);
        end
        step(0, 1, 0, 0, 6'd0, 16'h0);
        chk("resume_e1_vld", {31'b0, data_valid}, 32'd0);
        step(0, 1, 0, 0, 6'd0, 16'h0);
        chk("resume_e2_vld", {31'b0, data_valid}, 32'd1);
        chk("resume_e2_dout", {16'b0, data_out}, 32'h1234);
        step(0, 0, 0, 0, 6'd0, 16'h0);
        chk("freeze_hold_vld", {31'b0, data_valid}, 32'd1);
        step(0, 1, 0, 0, 6'd0, 16'h0);
        chk("strobe_end_vld", {31'b0, data_valid}, 32'd0);

        // Reset one cycle after a read is accepted: the read is discarded.
        step(0, 1, 1, 0, 6'd5, 16'h0);
        step(1, 1, 0, 0, 6'd0, 16'h0);
        chk("rst_dout", {16'b0, data_out}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        step(1, 1, 0, 0, 6'd0, 16'h0);
        wait_ready();
        chk("post_rst_vld", {31'b0, data_valid}, 32'd0);
        chk("post_rst_dout", {16'b0, data_out}, 32'd0);

        step(0, 1, 1, 0, 6'd5, 16'h0);
        step(0, 1, 1, 0, 6'd9, 16'h0);
        step(0, 1, 0, 0, 6'd0, 16'h0);
        chk("rd5_vld", {31'b0, data_valid}, 32'd1);
`ifdef RAM_SP_PIPE_CLEAR_EN
        chk("rd5_dout", {16'b0, data_out}, 32'h0000);
        step(0, 1, 0, 0, 6'd0, 16'h0);
        chk("rd9_cleared", {16'b0, data_out}, 32'h0000);
`else
        chk("rd5_dout", {16'b0, data_out}, 32'hBEEF);
        step(0, 1, 0, 0, 6'd0, 16'h0);
`endif

        // Random mixed traffic with occasional ce gaps and resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 6'($urandom_range(0, 15)),
                 16'($urandom));
        end
        for (int i = 0; i < 80; i++) step(0, 1, 0, 0, 6'd0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
